ahb_cmd_master: RTL and testbench

//  Synthesisable AHB-lite master; upstream neighbour of ahb_slave, driving its htrans/hwrite/haddr/hwdata.

---
 rtl/ahb_cmd_master.sv | 106 ++++++++++
 tb/tb_ahb_cmd_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - AHB-lite master issuing queued single-word commands as pipelined NONSEQ transfers
module ahb_cmd_master #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic [DATA_W-1:0] hrdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(CMD_DEPTH);

    logic [ENT_W-1:0]  fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // ADDR stage is a_valid/hwrite/haddr/a_wdata; DATA stage is d_valid/d_write/hwdata.
    logic              a_valid;
    logic [DATA_W-1:0] a_wdata;
    logic              d_valid;
    logic              d_write;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != FULL_CNT) && !hreset;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = hready && !fifo_empty;
    assign htrans     = a_valid ? 2'b10 : 2'b00;
    assign busy       = !fifo_empty || a_valid || d_valid;

    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // All stages advance together on hready; a low hready freezes the whole pipeline.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            a_valid   <= 1'b0;
            hwrite    <= 1'b0;
            haddr     <= '0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (hready) begin
                d_valid <= a_valid;
                d_write <= a_valid && hwrite;
                hwdata  <= (a_valid && hwrite) ? a_wdata : '0;
                if (d_valid && !d_write) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= hrdata;
                end
                if (fifo_empty) begin
                    a_valid <= 1'b0;
                end else begin
                    a_valid                   <= 1'b1;
                    {hwrite, haddr, a_wdata}  <= fifo_mem[rd_ptr];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - scoreboard bench for ahb_cmd_master with a behavioural AHB slave
module tb_ahb_cmd_master;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int CMD_DEPTH = 4;

    logic              hclk = 1'b0;
    logic              hreset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hready = 1'b1;
    logic [DATA_W-1:0] hrdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    ahb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH)) dut (
        .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    always #5 hclk = ~hclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    xfer_t             xfer_q[$];
    logic [DATA_W-1:0] rsp_q[$];
    xfer_t             dp;
    logic              dp_valid = 1'b0;
    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];
    int                n_cmp = 0;
    int                n_err = 0;
    int                run_len = 0;
    int                max_run = 0;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model plus bus/response scoreboard, run once per cycle on the falling edge.
    task automatic monitor();
        xfer_t x;
        if (hreset) begin
            dp_valid = 1'b0;
            xfer_q.delete();
            rsp_q.delete();
            run_len = 0;
            return;
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else                   chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
        end
        hrdata = (dp_valid && !dp.write) ? mem[dp.addr] : 32'hdead_beef;
        if (hready) begin
            if (dp_valid) begin
                chk(dp.write ? "hwdata_write" : "hwdata_read", hwdata, dp.wdata);
                if (dp.write) mem[dp.addr] = hwdata;
                dp_valid = 1'b0;
            end
            if (htrans == 2'b10) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (xfer_q.size() == 0) begin
                    chk("nonseq_unexpected", 32'(htrans), 32'd0);
                end else begin
                    x = xfer_q.pop_front();
                    chk("haddr", 32'(haddr), 32'(x.addr));
                    chk("hwrite", 32'(hwrite), 32'(x.write));
                    dp       = x;
                    dp_valid = 1'b1;
                end
            end else begin
                run_len = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge hclk);
        monitor();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int budget = 50;
        while (!cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        xfer_q.push_back('{write: w, addr: a, wdata: (w ? d : '0)});
        if (w) ref_mem[a] = d;
        else   rsp_q.push_back(ref_mem[a]);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 100;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        tick();
        chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
        chk("drain_xfer_q", 32'(xfer_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // reset held three cycles
        repeat (3) tick();
        hreset = 1'b0;
        #1;
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // single write with latency checks
        push(1'b1, 8'h0d, 32'h5a5a_5a5a);
        chk("w1_idle_before", 32'(htrans), 32'd0);
        tick();
        chk("w1_htrans", 32'(htrans), 32'd2);
        chk("w1_haddr", 32'(haddr), 32'h0d);
        chk("w1_hwrite", 32'(hwrite), 32'd1);
        tick();
        chk("w1_htrans_after", 32'(htrans), 32'd0);
        chk("w1_hwdata", hwdata, 32'h5a5a_5a5a);
        chk("w1_busy_data", 32'(busy), 32'd1);
        tick();
        chk("w1_busy_fall", 32'(busy), 32'd0);
        drain();

        // ten back-to-back writes
        max_run = 0;
        for (int i = 0; i < 10; i++) begin
            chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
            push(1'b1, 8'(8'h99 - i), 32'h0fff - 32'(i));
        end
        drain();
        chk("b2b_nonseq_run", 32'(max_run), 32'd10);

        // read after reset, then write/read pair
        push(1'b0, 8'h00, 32'h0);
        tick();
        chk("r0_htrans", 32'(htrans), 32'd2);
        tick();
        chk("r0_no_rsp_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("r0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r0_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        chk("r0_rsp_pulse", 32'(rsp_valid), 32'd0);
        push(1'b1, 8'h03, 32'h33);
        push(1'b0, 8'h03, 32'h0);
        drain();
        chk("r3_rsp_rdata_held", rsp_rdata, 32'h33);

        // stall during a write data phase while filling the FIFO
        push(1'b1, 8'h20, 32'habcd_1234);
        tick();
        tick();
        chk("st_hwdata_start", hwdata, 32'habcd_1234);
        hready     = 1'b0;
        hold_addr  = haddr;
        hold_wdata = hwdata;
        push(1'b1, 8'h41, 32'h1111_0041);
        push(1'b1, 8'h42, 32'h2222_0042);
        push(1'b0, 8'h41, 32'h0);
        push(1'b0, 8'h42, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("st_htrans", 32'(htrans), 32'd0);
            chk("st_haddr", 32'(haddr), 32'(hold_addr));
            chk("st_hwdata", hwdata, hold_wdata);
            chk("st_full", 32'(cmd_ready), 32'd0);
            chk("st_busy", 32'(busy), 32'd1);
            tick();
        end
        hready = 1'b1;
        tick();
        chk("st_resume_htrans", 32'(htrans), 32'd2);
        chk("st_resume_haddr", 32'(haddr), 32'h41);
        drain();

        // reset with three queued and one in flight
        push(1'b0, 8'h0d, 32'h0);
        tick();
        chk("rs_inflight", 32'(htrans), 32'd2);
        hready = 1'b0;
        push(1'b0, 8'h01, 32'h0);
        push(1'b0, 8'h02, 32'h0);
        push(1'b0, 8'h03, 32'h0);
        hreset = 1'b1;
        tick();
        chk("rs_htrans", 32'(htrans), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_hwdata", hwdata, 32'd0);
        hready = 1'b1;
        hreset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rs_post_idle", 32'(htrans), 32'd0);
            chk("rs_post_busy", 32'(busy), 32'd0);
        end

        // recovery after reset
        push(1'b1, 8'h77, 32'hcafe_0077);
        push(1'b0, 8'h77, 32'h0);
        drain();

        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) chk("mem_contents", mem[i], ref_mem[i]);
        end
        chk("mem_0d", mem[8'h0d], 32'h5a5a_5a5a);
        chk("mem_90", mem[8'h90], 32'h0ff6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
